// File: rtl/encoder_tx_sequencer.sv
// encoder_tx_sequencer
// Transmit-side symbol scheduler feeding an 8B/10B encoder pair.
// Arbitrates two byte requesters round-robin. Frames each packet with
// K27.7 (start) and K29.7 (end). Runs the link-alignment K28.5 sequence,
// fills gaps with K28.5 and forces a K28.5 at least every COMMA_PERIOD
// symbols. Holds the running-disparity register that the encoder uses and
// then updates. Emits one registered symbol per clock.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_enable                link enable; low forces the link OFF
//   i_req_valid/data/last   two byte-stream requesters (byte n on [8n+7:8n])
//   o_req_ready             per-requester accept strobe (combinational)
//   o_data8/o_datak         registered symbol byte and K flag
//   o_sym_valid             registered symbol-live flag
//   o_run_disp/i_run_disp   running disparity to / from the encoder
//   o_aligned               alignment sequence finished
//   o_grant                 requester owning the current/last packet
module encoder_tx_sequencer #(
    parameter int ALIGN_LEN    = 16,
    parameter int COMMA_PERIOD = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [1:0]  i_req_valid,
    input  logic [15:0] i_req_data,
    input  logic [1:0]  i_req_last,
    output logic [1:0]  o_req_ready,
    output logic [7:0]  o_data8,
    output logic        o_datak,
    output logic        o_sym_valid,
    output logic        o_run_disp,
    input  logic        i_run_disp,
    output logic        o_aligned,
    output logic        o_grant
);

    localparam int AW = $clog2(ALIGN_LEN + 1);
    localparam int CW = $clog2(COMMA_PERIOD);

    localparam logic [7:0]    K28_5         = 8'hBC;
    localparam logic [7:0]    K27_7         = 8'hFB;
    localparam logic [7:0]    K29_7         = 8'hFD;
    localparam logic [AW-1:0] ALIGN_LAST    = AW'(ALIGN_LEN - 1);
    localparam logic [CW-1:0] COMMA_DUE_CNT = CW'(COMMA_PERIOD - 2);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_ALIGN = 3'd1,
        ST_IDLE  = 3'd2,
        ST_SOF   = 3'd3,
        ST_DATA  = 3'd4,
        ST_EOF   = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [AW-1:0]   align_cnt_r;
    logic [AW-1:0]   align_cnt_s;
    logic [CW-1:0]   comma_cnt_r;
    logic [CW-1:0]   comma_cnt_s;
    logic            rr_r;
    logic            rr_s;
    logic            grant_s;
    logic            aligned_s;
    logic [7:0]      sym_s;
    logic            symk_s;
    logic            symv_s;
    logic [1:0]      ready_s;
    logic            comma_due_s;
    logic            pick_s;
    logic            gnt_valid_s;
    logic            gnt_last_s;
    logic [7:0]      gnt_data_s;

    // Next symbol must be K28.5 once COMMA_PERIOD-2 non-comma symbols went out.
    assign comma_due_s = (comma_cnt_r == COMMA_DUE_CNT);

    // With both requesting the rr pointer decides; otherwise the lone requester wins.
    assign pick_s = (i_req_valid == 2'b11) ? rr_r : i_req_valid[1];

    // Only the granted requester is looked at while a packet is open.
    assign gnt_valid_s = o_grant ? i_req_valid[1]     : i_req_valid[0];
    assign gnt_last_s  = o_grant ? i_req_last[1]      : i_req_last[0];
    assign gnt_data_s  = o_grant ? i_req_data[15:8]   : i_req_data[7:0];

    assign o_req_ready = ready_s;

    // Next-state, next-symbol and handshake decode.
    always_comb begin
        state_s   = state_r;
        sym_s     = K28_5;
        symk_s    = 1'b1;
        symv_s    = 1'b1;
        grant_s   = o_grant;
        rr_s      = rr_r;
        aligned_s = o_aligned;
        ready_s   = 2'b00;
        if (!i_enable) begin
            // Link dropped: any open packet is abandoned without an EOF.
            state_s   = ST_OFF;
            symv_s    = 1'b0;
            aligned_s = 1'b0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    symv_s    = 1'b0;
                    aligned_s = 1'b0;
                    state_s   = ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (align_cnt_r == ALIGN_LAST) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_ALIGN;
                    end
                end
                ST_IDLE: begin
                    aligned_s = 1'b1;
                    if (|i_req_valid) begin
                        grant_s = pick_s;
                        state_s = ST_SOF;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SOF: begin
                    sym_s   = K27_7;
                    state_s = ST_DATA;
                end
                ST_DATA: begin
                    ready_s[o_grant] = ~comma_due_s;
                    if (gnt_valid_s && !comma_due_s) begin
                        sym_s  = gnt_data_s;
                        symk_s = 1'b0;
                        if (gnt_last_s) begin
                            state_s = ST_EOF;
                        end else begin
                            state_s = ST_DATA;
                        end
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_EOF: begin
                    // A due comma delays the EOF by one K28.5 so the spacing bound holds.
                    if (comma_due_s) begin
                        state_s = ST_EOF;
                    end else begin
                        sym_s   = K29_7;
                        rr_s    = ~o_grant;
                        state_s = ST_IDLE;
                    end
                end
                default: begin
                    symv_s    = 1'b0;
                    aligned_s = 1'b0;
                    state_s   = ST_OFF;
                end
            endcase
        end

        if (state_r == ST_ALIGN) begin
            align_cnt_s = align_cnt_r + AW'(1);
        end else begin
            align_cnt_s = {AW{1'b0}};
        end

        // Restart on every K28.5 and whenever the link is silent.
        if (!symv_s || (symk_s && (sym_s == K28_5))) begin
            comma_cnt_s = {CW{1'b0}};
        end else begin
            comma_cnt_s = comma_cnt_r + CW'(1);
        end
    end

    // State, counters and registered symbol outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_OFF;
            align_cnt_r <= {AW{1'b0}};
            comma_cnt_r <= {CW{1'b0}};
            rr_r        <= 1'b0;
            o_grant     <= 1'b0;
            o_aligned   <= 1'b0;
            o_data8     <= K28_5;
            o_datak     <= 1'b1;
            o_sym_valid <= 1'b0;
            o_run_disp  <= 1'b0;
        end else begin
            state_r     <= state_s;
            align_cnt_r <= align_cnt_s;
            comma_cnt_r <= comma_cnt_s;
            rr_r        <= rr_s;
            o_grant     <= grant_s;
            o_aligned   <= aligned_s;
            o_data8     <= sym_s;
            o_datak     <= symk_s;
            o_sym_valid <= symv_s;
            // The encoder's returned disparity belongs to the symbol now on the bus.
            if (o_sym_valid) begin
                o_run_disp <= i_run_disp;
            end else begin
                o_run_disp <= o_run_disp;
            end
        end
    end

endmodule

// File: doc/encoder_tx_sequencer.md
Name: encoder_tx_sequencer

Overview:
Transmit-side symbol scheduler placed directly in front of the 8B/10B encoder pair (5b/6b + 3b/4b).
- Arbitrates two byte-stream requesters round-robin and frames each packet with K27.7 (start) and K29.7 (end).
- Runs a link-alignment comma sequence, fills gaps with K28.5, and inserts periodic K28.5 commas.
- Owns the running-disparity register that the encoder consumes and returns.
- Emits one symbol (data8 + k flag) per clock.

Parameters:
ALIGN_LEN, 16, number of K28.5 symbols sent after enable before the link is declared aligned (≥1).
COMMA_PERIOD, 256, max symbols between consecutive K28.5 while aligned (power of 2, ≥8).

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, asynchronous, active-low
i_enable  input  1  link enable; low forces OFF
i_req_valid  input  2  per-requester byte valid
i_req_data  input  16  requester n byte on [8n+7:8n]
i_req_last  input  2  per-requester last byte of packet
o_req_ready  output  2  per-requester byte accepted when valid&ready at rising edge
o_data8  output  8  symbol byte to encoder (registered)
o_datak  output  1  1 = o_data8 is a K character (registered)
o_sym_valid  output  1  1 = symbol on o_data8/o_datak is live (registered)
o_run_disp  output  1  current running disparity to encoder (0 = RD-)
i_run_disp  input  1  next running disparity returned by encoder for current symbol
o_aligned  output  1  alignment sequence complete, link usable
o_grant  output  1  index of requester owning current/last packet

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-low, on i_rst_n.
- Reset values:
  - state = OFF, o_data8 = 8'hBC, o_datak = 1, o_sym_valid = 0.
  - o_run_disp = 0, o_aligned = 0, o_grant = 0, rr pointer = 0.
  - comma counter = 0, o_req_ready = 0.
- Symbol constants: K28.5 = 8'hBC, K27.7 = 8'hFB, K29.7 = 8'hFD, all with o_datak = 1.
- Running disparity:
  - o_run_disp loads i_run_disp on every edge where o_sym_valid = 1.
  - It holds otherwise, including through OFF.
  - It is cleared only by reset.
- Comma counter:
  - Counts symbols emitted since the last K28.5; cleared whenever K28.5 is emitted.
  - comma_due = (counter == COMMA_PERIOD-2), so the next symbol is forced to K28.5.
- States; the next-cycle output symbol is given in brackets:
  - OFF: sym_valid = 0. If i_enable, go to ALIGN.
  - ALIGN: emit K28.5 ALIGN_LEN times, then go to IDLE and set o_aligned = 1.
  - IDLE: emit K28.5.
    - If any valid: grant = rr pointer when both are valid, else the one valid requester. Go to SOF.
  - SOF: emit K27.7, go to DATA.
  - DATA: o_req_ready[grant] = !comma_due; other ready = 0. Ready is combinational from state/grant/counter.
    - valid & ready: emit the byte (k = 0). If last, go to EOF.
    - !valid or comma_due: emit K28.5 filler and stay in DATA.
  - EOF: emit K29.7, rr pointer = ~grant, go to IDLE.
- Latency: a byte accepted at edge N appears on o_data8 after edge N (one-cycle registered). SOF follows one IDLE cycle after valid is first seen.
- o_grant updates on entry to SOF and holds until the next SOF.
- i_enable low in any state: next state is OFF, o_req_ready = 0 immediately (combinational), o_aligned = 0, o_sym_valid = 0.
  - A partial packet is abandoned with no EOF; the requester must restart the packet.
  - The rr pointer is unchanged.
- i_enable re-asserted: full ALIGN sequence again; the counter restarts from 0.
- Valid deasserting mid-packet is legal (filler). i_req_last is only sampled with valid & ready.
- Inputs from the non-granted requester are ignored until the next IDLE arbitration.

Test Plan:
1. Reset, then i_enable = 1 with ALIGN_LEN = 16: exactly 16 consecutive BC/k = 1 symbols with sym_valid = 1, then o_aligned = 1; o_run_disp toggles each comma when the encoder model flips RD.
2. Requester 0 sends 3 bytes 11, 22, 33 (last on 33): output stream FB(k), 11, 22, 33, FD(k), then BC idle; ready[1] = 0 throughout; o_grant = 0.
3. Both requesters valid in IDLE after reset: req0 packet is framed first; after its FD, req1 is granted (o_grant = 1); next contention grants req0.
4. COMMA_PERIOD = 8, 20-byte packet: a BC(k) is inserted so no run of 8 symbols lacks BC; o_req_ready drops for exactly the insertion cycle; all data bytes are delivered in order.
5. Valid bubble of 2 cycles mid-packet: two BC fillers appear between data bytes; the packet completes with FD.
6. i_enable dropped after 2 data bytes: next cycle sym_valid = 0, o_aligned = 0, ready = 0, no FD. Re-enable: 16 BC, then the requester's restarted packet is framed; o_run_disp is continuous across the gap.
